out_shift_ctrl: RTL and testbench
=================================

// Module: out_shift_ctrl
// PURPOSE
//  Sequencer for the per-column output shift/delay register. It validates and loads the
//  column-count configuration and clears the delay line. It then streams partial sums
//  with a valid/ready handshake, pulsing the shift-load strobe once per accepted sample.
//  It flags which outputs are valid, i.e. those that have left the delay line once the
//  fill delay (filter_size - columns) has elapsed. Sits between the PE-column result
//  bus and the output writer.
// PARAMETERS
//  N            3              max filter size (delay line holds N-1 entries)
//  NUM_COL_WIDTH $clog2(N+1)   width of column-count / filter-size fields
//  LEN_WIDTH    16             width of per-job sample count
// PORTS
//  clk_i               in   1              clock, all logic on rising edge
//  rst_i               in   1              synchronous, active-high reset
//  start_i             in   1              job request; sampled only in IDLE
//  filter_size_i       in   NUM_COL_WIDTH  filter size for job (1..N)
//  num_cols_i          in   NUM_COL_WIDTH  active columns for job (1..filter_size_i)
//  num_samples_i       in   LEN_WIDTH      samples to accept for job (>=1)
//  in_valid_i          in   1              upstream sample valid
//  in_ready_o          out  1              upstream sample accepted when in_valid_i & in_ready_o
//  out_ready_i         in   1              downstream can take an output
//  out_valid_o         out  1              datapath output is a valid result this cycle
//  number_of_columns_o out  NUM_COL_WIDTH  column count driven to datapath
//  number_of_columns_ld_o  out 1           load column count into datapath
//  number_of_columns_rst_o out 1           clear datapath column count
//  out_reg_shift_rst_o out  1              clear datapath delay line
//  out_reg_shift_ld_o  out  1              shift delay line (one per accepted sample)
//  filter_size_o       out  NUM_COL_WIDTH  latched filter size driven to datapath
//  busy_o              out  1              high in any state but IDLE
//  done_o              out  1              one-cycle pulse on job completion
//  err_cfg_o           out  1              one-cycle pulse, start rejected
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters 0; latched cfg 0. Overrides everything, mid-job too.
//  FSM: IDLE -> CLEAR -> LOAD -> RUN -> DONE -> IDLE.
//   IDLE: on start_i, cfg is legal iff 1<=filter_size_i<=N, 1<=num_cols_i<=filter_size_i,
//    num_samples_i!=0. Legal: latch fs/nc/len, go to CLEAR. Illegal: err_cfg_o=1 next cycle, stay IDLE.
//   CLEAR (1 cycle): out_reg_shift_rst_o=1, number_of_columns_rst_o=1.
//   LOAD (1 cycle): number_of_columns_ld_o=1, number_of_columns_o=latched nc;
//    delay D = fs - nc (0..N-1) registered.
//   RUN: handles accepted samples; when len samples have been accepted, go to DONE.
//   DONE (1 cycle): done_o=1 -> IDLE. start_i is ignored outside IDLE.
//  number_of_columns_o, filter_size_o hold latched values from LOAD until next job/reset.
//  RUN handshake (combinational from state/counters/out_ready_i):
//   emit = (acc_cnt >= D).
//   in_ready_o = RUN & (~emit | out_ready_i).
//   accept = in_valid_i & in_ready_o.
//   out_reg_shift_ld_o = accept; out_valid_o = accept & emit.
//  acc_cnt: LEN_WIDTH; increments per accept. emit saturates true once acc_cnt>=D.
//   D=0: every accept is emitted (direct path). Last accept (acc_cnt==len-1) -> DONE next edge.
//  Filling (~emit): samples accepted regardless of out_ready_i; no out_valid_o.
//  Outputs emitted per job = len - min(D,len). Samples left in line are discarded (cleared next job).
//  in_valid_i without in_ready_o: no shift, counters hold. No combinational path in_valid_i -> in_ready_o.
// TESTING
//  T1 rst mid-RUN (N=3,fs=3,nc=1,len=5, after 2 accepts) -> next cycle IDLE, all outputs 0, busy_o=0.
//  T2 fs=3,nc=1,len=5, in_valid_i=1, out_ready_i=1 -> CLEAR,LOAD 1 cycle each; 5 shift pulses;
//     out_valid_o on accepts 3,4,5; done_o 1 cycle after 5th.
//  T3 fs=2,nc=2,len=4 (D=0) -> out_valid_o on all 4 accepts; number_of_columns_o=2 after LOAD.
//  T4 fs=3,nc=1,len=6, out_ready_i=0 -> 2 accepts (fill), then in_ready_o=0, no shift;
//     out_ready_i=1 -> resumes, 4 outputs.
//  T5 start with nc=3,fs=2 / fs=0 / len=0 -> err_cfg_o pulse each, busy_o stays 0.
//  T6 start_i held high through DONE -> new job begins from IDLE (re-CLEAR);
//     start during RUN ignored; len=1,D=2 -> 0 outputs, done_o.

Source files
------------

// File: rtl/out_shift_ctrl.sv
// out_shift_ctrl: sequences config load, delay-line clear and sample streaming for the output shift register
module out_shift_ctrl #(
   parameter int N             = 3,
   parameter int NUM_COL_WIDTH = $clog2(N + 1),
   parameter int LEN_WIDTH     = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic [NUM_COL_WIDTH-1:0] filter_size_i,
   input  logic [NUM_COL_WIDTH-1:0] num_cols_i,
   input  logic [LEN_WIDTH-1:0]     num_samples_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic                     out_ready_i,
   output logic                     out_valid_o,
   output logic [NUM_COL_WIDTH-1:0] number_of_columns_o,
   output logic                     number_of_columns_ld_o,
   output logic                     number_of_columns_rst_o,
   output logic                     out_reg_shift_rst_o,
   output logic                     out_reg_shift_ld_o,
   output logic [NUM_COL_WIDTH-1:0] filter_size_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_cfg_o
);
   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, DONE} state_t;
   localparam logic [NUM_COL_WIDTH-1:0] N_W = NUM_COL_WIDTH'(N);
   state_t                   state_q, state_d;
   logic [NUM_COL_WIDTH-1:0] fs_q, fs_d, nc_q, nc_d, dly_q, dly_d, ncol_q, ncol_d, fso_q, fso_d;
   logic [LEN_WIDTH-1:0]     len_q, len_d, acc_q, acc_d;
   logic                     err_q, err_d;
   logic                     cfg_ok, emit, rdy, accept, last;
   // config legality check and the run-time handshake, purely from state, counters and out_ready_i
   always_comb begin
      cfg_ok = (filter_size_i != '0) && (filter_size_i <= N_W) && (num_cols_i != '0)
             && (num_cols_i <= filter_size_i) && (num_samples_i != '0);
      emit   = acc_q >= LEN_WIDTH'(dly_q);
      rdy    = (state_q == RUN) && (!emit || out_ready_i);
      accept = in_valid_i && rdy;
      last   = acc_q == len_q - LEN_WIDTH'(1);
   end
   // datapath strobes and status decoded from state; column count and filter size are live in LOAD
   always_comb begin
      in_ready_o              = rdy;
      out_reg_shift_ld_o      = accept;
      out_valid_o             = accept && emit;
      out_reg_shift_rst_o     = state_q == CLEAR;
      number_of_columns_rst_o = state_q == CLEAR;
      number_of_columns_ld_o  = state_q == LOAD;
      number_of_columns_o     = (state_q == LOAD) ? nc_q : ncol_q;
      filter_size_o           = (state_q == LOAD) ? fs_q : fso_q;
      busy_o                  = state_q != IDLE;
      done_o                  = state_q == DONE;
      err_cfg_o               = err_q;
   end
   // next-state: latch cfg on a legal start, compute the fill delay in LOAD, count accepts in RUN
   always_comb begin
      state_d = state_q;
      fs_d    = fs_q;
      nc_d    = nc_q;
      len_d   = len_q;
      acc_d   = acc_q;
      dly_d   = dly_q;
      ncol_d  = ncol_q;
      fso_d   = fso_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i && cfg_ok) begin
               fs_d    = filter_size_i;
               nc_d    = num_cols_i;
               len_d   = num_samples_i;
               acc_d   = '0;
               state_d = CLEAR;
            end
            err_d = start_i && !cfg_ok;
         end
         CLEAR: state_d = LOAD;
         LOAD: begin
            dly_d   = fs_q - nc_q;
            ncol_d  = nc_q;
            fso_d   = fs_q;
            state_d = RUN;
         end
         RUN: begin
            acc_d   = accept ? acc_q + LEN_WIDTH'(1) : acc_q;
            state_d = (accept && last) ? DONE : RUN;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state and configuration registers, cleared by synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         fs_q    <= '0;
         nc_q    <= '0;
         len_q   <= '0;
         acc_q   <= '0;
         dly_q   <= '0;
         ncol_q  <= '0;
         fso_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         fs_q    <= fs_d;
         nc_q    <= nc_d;
         len_q   <= len_d;
         acc_q   <= acc_d;
         dly_q   <= dly_d;
         ncol_q  <= ncol_d;
         fso_q   <= fso_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_out_shift_ctrl.sv
// tb_out_shift_ctrl: scoreboard bench for out_shift_ctrl with directed jobs
module tb_out_shift_ctrl;
   localparam int NW = 2;
   localparam int LW = 16;
   localparam int K_OUT = 0, K_DONE = 1, K_ERR = 2;
   logic          clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
   logic [NW-1:0] filter_size_i = '0, num_cols_i = '0;
   logic [LW-1:0] num_samples_i = '0;
   logic          in_ready_o, out_valid_o, number_of_columns_ld_o, number_of_columns_rst_o;
   logic          out_reg_shift_rst_o, out_reg_shift_ld_o, busy_o, done_o, err_cfg_o;
   logic [NW-1:0] number_of_columns_o, filter_size_o;
   logic [13:0]   all_outs;
   typedef struct {int kind; int val;} ev_t;
   ev_t sb[$];
   int  checks = 0, errors = 0, acc_seen = 0;

   out_shift_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .filter_size_i(filter_size_i),
      .num_cols_i(num_cols_i), .num_samples_i(num_samples_i), .in_valid_i(in_valid_i),
      .in_ready_o(in_ready_o), .out_ready_i(out_ready_i), .out_valid_o(out_valid_o),
      .number_of_columns_o(number_of_columns_o), .number_of_columns_ld_o(number_of_columns_ld_o),
      .number_of_columns_rst_o(number_of_columns_rst_o), .out_reg_shift_rst_o(out_reg_shift_rst_o),
      .out_reg_shift_ld_o(out_reg_shift_ld_o), .filter_size_o(filter_size_o), .busy_o(busy_o),
      .done_o(done_o), .err_cfg_o(err_cfg_o)
   );

   assign all_outs = {in_ready_o, out_valid_o, number_of_columns_o, number_of_columns_ld_o,
                      number_of_columns_rst_o, out_reg_shift_rst_o, out_reg_shift_ld_o,
                      filter_size_o, busy_o, done_o, err_cfg_o};

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int k, input int v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      sb.push_back(e);
   endtask

   task automatic pop_chk(input string name, input int k, input int v);
      ev_t e;
      if (sb.size() == 0) chk({name, "_unexpected"}, 32'(sb.size()), 32'd1);
      else begin
         e = sb.pop_front();
         chk(name, 32'(k * 1000 + v), 32'(e.kind * 1000 + e.val));
      end
   endtask

   // monitor: counts shift pulses per job and pops the scoreboard on each output event
   always @(negedge clk_i) begin
      if (rst_i) acc_seen = 0;
      else begin
         if (out_reg_shift_rst_o) acc_seen = 0;
         if (out_reg_shift_ld_o) acc_seen++;
         if (out_valid_o) begin
            chk("out_valid_without_shift", 32'(out_reg_shift_ld_o), 32'd1);
            pop_chk("out_event", K_OUT, acc_seen);
         end
         if (done_o) pop_chk("done_event", K_DONE, acc_seen);
         if (err_cfg_o) pop_chk("err_event", K_ERR, 0);
      end
   end

   task automatic start_job(input int fs, input int nc, input int len);
      @(posedge clk_i); #1;
      start_i = 1'b1;
      filter_size_i = NW'(fs);
      num_cols_i = NW'(nc);
      num_samples_i = LW'(len);
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (busy_o && n < max) begin
         @(negedge clk_i);
         n++;
      end
      chk("timeout_idle", 32'(busy_o), 32'd0);
   endtask

   task automatic bad_start(input int fs, input int nc, input int len);
      push(K_ERR, 0);
      start_job(fs, nc, len);
      @(negedge clk_i);
      chk("bad_busy", 32'(busy_o), 32'd0);
      chk("bad_err_now", 32'(err_cfg_o), 32'd1);
      @(negedge clk_i);
      chk("bad_err_pulse", 32'(err_cfg_o), 32'd0);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("reset_outs", 32'(all_outs), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      // T1: reset in the middle of RUN
      in_valid_i = 1'b1;
      out_ready_i = 1'b1;
      start_job(3, 1, 5);
      repeat (4) @(posedge clk_i);
      #1 in_valid_i = 1'b0;
      @(negedge clk_i);
      chk("t1_busy", 32'(busy_o), 32'd1);
      chk("t1_fs", 32'(filter_size_o), 32'd3);
      chk("t1_ready", 32'(in_ready_o), 32'd1);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("t1_reset_outs", 32'(all_outs), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      // T2: D=2, three outputs out of five accepts
      in_valid_i = 1'b1;
      push(K_OUT, 3); push(K_OUT, 4); push(K_OUT, 5); push(K_DONE, 5);
      start_job(3, 1, 5);
      @(negedge clk_i);
      chk("t2_clear", 32'({out_reg_shift_rst_o, number_of_columns_rst_o, busy_o, number_of_columns_ld_o}), 32'b1110);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("t2_load", 32'({number_of_columns_ld_o, out_reg_shift_rst_o, in_ready_o}), 32'b100);
      chk("t2_ncols", 32'(number_of_columns_o), 32'd1);
      chk("t2_fs", 32'(filter_size_o), 32'd3);
      wait_idle(40);
      // T3: D=0, every accept emitted
      push(K_OUT, 1); push(K_OUT, 2); push(K_OUT, 3); push(K_OUT, 4); push(K_DONE, 4);
      start_job(2, 2, 4);
      wait_idle(40);
      chk("t3_ncols", 32'(number_of_columns_o), 32'd2);
      chk("t3_fs", 32'(filter_size_o), 32'd2);
      // T4: downstream stall after fill, start during RUN ignored
      out_ready_i = 1'b0;
      push(K_OUT, 3); push(K_OUT, 4); push(K_OUT, 5); push(K_OUT, 6); push(K_DONE, 6);
      start_job(3, 1, 6);
      repeat (6) @(posedge clk_i);
      #1;
      start_i = 1'b1;
      filter_size_i = 2'd2;
      num_cols_i = 2'd2;
      num_samples_i = 16'd3;
      @(negedge clk_i);
      chk("t4_stall_ready", 32'(in_ready_o), 32'd0);
      chk("t4_stall_shift", 32'(out_reg_shift_ld_o), 32'd0);
      chk("t4_stall_busy", 32'(busy_o), 32'd1);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      @(negedge clk_i);
      chk("t4_ncols_kept", 32'(number_of_columns_o), 32'd1);
      chk("t4_fs_kept", 32'(filter_size_o), 32'd3);
      chk("t4_still_stalled", 32'(in_ready_o), 32'd0);
      out_ready_i = 1'b1;
      wait_idle(40);
      // T5: rejected configurations
      bad_start(2, 3, 1);
      bad_start(0, 1, 1);
      bad_start(2, 1, 0);
      bad_start(3, 0, 4);
      // T6: start held through DONE restarts from IDLE; len=1 with D=2 gives no outputs
      push(K_DONE, 1); push(K_DONE, 1);
      @(posedge clk_i); #1;
      start_i = 1'b1;
      filter_size_i = 2'd3;
      num_cols_i = 2'd1;
      num_samples_i = 16'd1;
      n = 0;
      while (!done_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      chk("t6_done_seen", 32'(done_o), 32'd1);
      @(posedge clk_i); #1;
      chk("t6_idle_gap", 32'(busy_o), 32'd0);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      @(negedge clk_i);
      chk("t6_reclear", 32'({out_reg_shift_rst_o, busy_o}), 32'b11);
      wait_idle(40);
      repeat (2) @(negedge clk_i);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
